vend_core: RTL and testbench
============================

VEND_CORE -- requirements
Module: vend_core

Interface
REQ-001 Parameter N_ITEMS, default 3, number of selectable products (index 0 = cola, 1 = tea, 2 = milk).
REQ-002 Parameter CREDIT_W, default 8, credit/price width, in units of 0.5 yuan.
REQ-003 Parameter PRICES, default {8'd6, 8'd4, 8'd3}, packed N_ITEMS*CREDIT_W price vector; slice i is the price of item i (cola 1.5, tea 2.0, milk 3.0 yuan).
REQ-004 Parameter MAX_CREDIT, default 40, highest credit accepted (20.0 yuan).
REQ-005 clk  input  1  system clock; all logic is rising-edge.
REQ-006 rst  input  1  reset; one clock, synchronous, active-high.
REQ-007 coin_half  input  1  level; a rising edge inserts 1 unit.
REQ-008 coin_one  input  1  level; a rising edge inserts 2 units.
REQ-009 sel  input  N_ITEMS  level per item; a rising edge is a purchase request.
REQ-010 account  input  1  level; a rising edge is a settle/refund request.
REQ-011 credit  output  CREDIT_W  current registered credit.
REQ-012 dispense  output  N_ITEMS  one-cycle one-hot pulse for the vended item.
REQ-013 change_valid  output  1  one-cycle pulse; change_amt is valid while it is high.
REQ-014 change_amt  output  CREDIT_W  refund amount; holds its last value otherwise.
REQ-015 err_short  output  1  one-cycle pulse when a purchase is refused for low credit.
REQ-016 coin_reject  output  1  one-cycle pulse when a coin is refused because of MAX_CREDIT.
REQ-017 busy  output  1  high in DISPENSE and CHANGE states.

Function
REQ-018 All inputs pass through a rising-edge detector (previous-sample register); level-held inputs act only once.
REQ-019 All outputs are registered and respond on the clock edge that first samples the input high (1-cycle latency).
REQ-020 State machine: IDLE (credit==0), CREDIT, DISPENSE, CHANGE.
REQ-021 IDLE: a coin edge adds its value and moves to CREDIT; sel edges assert err_short; account edges are ignored.
REQ-022 CREDIT: a sel edge with credit>=price moves to DISPENSE; dispense pulses and credit drops by the price.
REQ-023 CREDIT: a sel edge with credit<price pulses err_short; credit and state are unchanged.
REQ-024 CREDIT: an account edge moves to CHANGE; change_valid pulses, change_amt=credit, credit=0.
REQ-025 DISPENSE and CHANGE each last exactly one cycle, then go to CREDIT if credit>0, otherwise to IDLE.
REQ-026 In DISPENSE and CHANGE, sel and account edges are discarded; coin edges are still credited.
REQ-027 Both coin edges in the same cycle add 3 units.
REQ-028 If credit+coin value > MAX_CREDIT, the whole coin group is refused, coin_reject pulses, and credit is unchanged.
REQ-029 Multiple sel edges in one cycle: the lowest index wins; the others are discarded.
REQ-030 Precedence within a cycle: account over sel.
REQ-031 Same-cycle coin arithmetic: a coin and an account edge refund credit+coin; a coin and a sel edge compare the price against the pre-coin credit, then add the coin to the remainder.
REQ-032 Arithmetic is unsigned CREDIT_W; underflow cannot occur by construction; MAX_CREDIT must be < 2^CREDIT_W.

Reset
REQ-033 On rst: state IDLE; credit 0; change_amt 0; all pulse outputs and busy 0; edge registers loaded with the current inputs, so levels held through reset do not fire.
REQ-034 rst mid-DISPENSE or mid-CHANGE aborts: no further pulses, and credit is lost (0).

Structure
REQ-035 Package vend_pkg holds the state encoding, the coin unit values (HALF=1, ONE=2), and the default price constants.
REQ-036 One sub-module, vend_edge_det, is the parametrised-width rising-edge detector, instantiated for coins, sel and account.

Verification
REQ-037 Insert coin_half, then coin_one, then select tea -> credit 1, then 3; err_short pulses; credit stays 3.
REQ-038 Insert 2x coin_one, then select cola -> dispense=3'b001 for one cycle; credit 1; busy high one cycle; then account -> change_valid with change_amt=1; credit 0; IDLE.
REQ-039 Hold coin_half high for 10 cycles -> credit 1 only; sel and coin_one rising in the same cycle with credit=6 (milk) -> dispense milk, final credit 2.
REQ-040 Credit 39, then both coins in one cycle -> coin_reject pulses, credit 39; coin_half -> credit 40; coin_half -> coin_reject pulses.
REQ-041 Credit 6, sel=3'b111 edge -> only cola dispensed, credit 3; account and sel edges in the same cycle -> change only, change_amt=3.
REQ-042 Credit 4, rst asserted on the DISPENSE cycle -> next cycle credit 0, no dispense or change pulse, IDLE; a held sel after reset does not fire.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending core: FSM encoding, coin values and
// the default product price table (all amounts in units of 0.5 yuan).
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   localparam int unsigned COIN_HALF = 1;
   localparam int unsigned COIN_ONE  = 2;

   localparam int unsigned DEF_N_ITEMS    = 3;
   localparam int unsigned DEF_CREDIT_W   = 8;
   localparam int unsigned DEF_MAX_CREDIT = 40;

   // Slice i is the price of item i: cola 3, tea 4, milk 6.
   localparam logic [23:0] DEF_PRICES = {8'd6, 8'd4, 8'd3};

endpackage

// File: rtl/vend_edge_det.sv
// Rising-edge detector of parametrised width. The previous-sample register
// always loads the current level, so during reset it captures held inputs
// and those levels never produce an edge afterwards.
module vend_edge_det #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [W-1:0] prev;

   // Track last sampled level (reset and normal operation behave alike)
   always_ff @(posedge clk) begin
      prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/vend_core.sv
// Vending machine controller: accepts half/one yuan coins, vends the lowest
// selected affordable item, refunds on account, and exposes its FSM state.
// There are no handshakes: every request is a rising edge on a level input
// and every response is a one-cycle registered pulse one clock later.
module vend_core
   import vend_pkg::*;
#(
   parameter int                          N_ITEMS    = DEF_N_ITEMS,
   parameter int                          CREDIT_W   = DEF_CREDIT_W,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = DEF_PRICES,
   parameter int                          MAX_CREDIT = DEF_MAX_CREDIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_half,
   input  logic                coin_one,
   input  logic [N_ITEMS-1:0]  sel,
   input  logic                account,
   output logic [CREDIT_W-1:0] credit,
   output logic [N_ITEMS-1:0]  dispense,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                err_short,
   output logic                coin_reject,
   output logic                busy,
   output state_t              fsm_state
);

   localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

   logic [1:0]          coin_rise;
   logic [N_ITEMS-1:0]  sel_rise;
   logic                acct_rise;

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] coin_val, base, sum, credit_nxt, price_sel;
   logic [N_ITEMS-1:0]  sel_onehot;
   logic                sel_hit;
   logic                do_change, do_vend, do_short, coin_ok, coin_rej;

   logic [N_ITEMS-1:0]  dispense_nxt;
   logic [CREDIT_W-1:0] change_amt_nxt;
   logic                change_valid_nxt, err_short_nxt, coin_reject_nxt, busy_nxt;

   vend_edge_det #(.W(2)) u_coin_edge (
      .clk   (clk),
      .level ({coin_one, coin_half}),
      .rise  (coin_rise)
   );

   vend_edge_det #(.W(N_ITEMS)) u_sel_edge (
      .clk   (clk),
      .level (sel),
      .rise  (sel_rise)
   );

   vend_edge_det #(.W(1)) u_acct_edge (
      .clk   (clk),
      .level (account),
      .rise  (acct_rise)
   );

   // Value of the coins arriving this cycle (both together add 3)
   always_comb begin
      coin_val = '0;
      if (coin_rise[0]) coin_val = coin_val + CREDIT_W'(COIN_HALF);
      if (coin_rise[1]) coin_val = coin_val + CREDIT_W'(COIN_ONE);
   end

   // Pick the lowest-index selection edge and look up its price
   always_comb begin
      sel_hit    = 1'b0;
      sel_onehot = '0;
      price_sel  = '0;
      for (int i = N_ITEMS - 1; i >= 0; i--) begin
         if (sel_rise[i]) begin
            sel_hit       = 1'b1;
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            price_sel     = PRICES[i*CREDIT_W +: CREDIT_W];
         end
      end
   end

   // Arbitrate account/sel/coins; purchase uses pre-coin credit, coin lands on the remainder
   always_comb begin
      do_change  = (state == ST_CREDIT) && acct_rise;
      do_vend    = (state == ST_CREDIT) && !acct_rise && sel_hit && (credit >= price_sel);
      do_short   = sel_hit && ((state == ST_IDLE) ||
                   ((state == ST_CREDIT) && !acct_rise && (credit < price_sel)));
      base       = do_vend ? (credit - price_sel) : credit;
      coin_ok    = (coin_val != '0) && (({1'b0, base} + {1'b0, coin_val}) <= MAX_SUM);
      coin_rej   = (coin_val != '0) && !coin_ok;
      sum        = coin_ok ? (base + coin_val) : base;
      credit_nxt = do_change ? '0 : sum;
   end

   // Next-state: DISPENSE/CHANGE last one cycle, then CREDIT or IDLE by credit
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (credit_nxt != '0) state_nxt = ST_CREDIT;
         end
         ST_CREDIT: begin
            if (do_change)    state_nxt = ST_CHANGE;
            else if (do_vend) state_nxt = ST_DISPENSE;
         end
         default: begin
            state_nxt = (credit_nxt != '0) ? ST_CREDIT : ST_IDLE;
         end
      endcase
   end

   // Output decode: values the output registers take on this edge
   always_comb begin
      dispense_nxt     = do_vend ? sel_onehot : '0;
      change_valid_nxt = do_change;
      change_amt_nxt   = do_change ? sum : change_amt;
      err_short_nxt    = do_short;
      coin_reject_nxt  = coin_rej;
      busy_nxt         = (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
   end

   // State and credit register; reset drops any credit, even mid-transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         credit <= '0;
      end else begin
         state  <= state_nxt;
         credit <= credit_nxt;
      end
   end

   // Registered outputs; change_amt holds its last refund between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         dispense     <= '0;
         change_valid <= 1'b0;
         change_amt   <= '0;
         err_short    <= 1'b0;
         coin_reject  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         dispense     <= dispense_nxt;
         change_valid <= change_valid_nxt;
         change_amt   <= change_amt_nxt;
         err_short    <= err_short_nxt;
         coin_reject  <= coin_reject_nxt;
         busy         <= busy_nxt;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_vend_core.sv
// Bench for vend_core: table of directed vectors, a reset-abort sequence,
// then random stimulus scored against a transaction-level model.
module tb_vend_core;
   import vend_pkg::*;

   localparam int OBS_W = 25;
   localparam int MAX_C = 40;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_half = 1'b0;
   logic       coin_one = 1'b0;
   logic       account = 1'b0;
   logic [2:0] sel = 3'b000;
   logic [7:0] credit;
   logic [2:0] dispense;
   logic       change_valid;
   logic [7:0] change_amt;
   logic       err_short;
   logic       coin_reject;
   logic       busy;
   state_t     fsm_state;

   always #5 clk = ~clk;

   vend_core dut (
      .clk          (clk),
      .rst          (rst),
      .coin_half    (coin_half),
      .coin_one     (coin_one),
      .sel          (sel),
      .account      (account),
      .credit       (credit),
      .dispense     (dispense),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .err_short    (err_short),
      .coin_reject  (coin_reject),
      .busy         (busy),
      .fsm_state    (fsm_state)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [OBS_W-1:0] exp_q[$];

   function automatic logic [OBS_W-1:0] pack(int cr, logic [2:0] d, logic cv, int amt,
                                             logic err, logic rej, logic bsy, state_t st);
      logic [7:0] cr8, amt8;
      cr8  = cr[7:0];
      amt8 = amt[7:0];
      return {cr8, d, cv, amt8, err, rej, bsy, st};
   endfunction

   function automatic string show(logic [OBS_W-1:0] v);
      return $sformatf("credit=%0d disp=%b cv=%b amt=%0d err=%b rej=%b busy=%b st=%0d",
                       v[24:17], v[16:14], v[13], v[12:5], v[4], v[3], v[2], v[1:0]);
   endfunction

   task automatic check(input string name, input int idx);
      logic [OBS_W-1:0] got, exp;
      got = pack(int'(credit), dispense, change_valid, int'(change_amt),
                 err_short, coin_reject, busy, fsm_state);
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %s, expected %s", name, idx, show(got), show(exp));
      end
   endtask

   // ---------------- reference model ----------------
   // Transaction view: credit in plain integers, phase tells whether the
   // machine is in its one-cycle vend/refund phase.
   int     m_credit = 0;
   int     m_amt    = 0;
   state_t m_phase  = ST_IDLE;
   bit     mp_h = 1'b0, mp_o = 1'b0, mp_a = 1'b0;
   bit [2:0] mp_s = 3'b000;
   int     price[3] = '{3, 4, 6};

   function automatic logic [OBS_W-1:0] model_step(bit h, bit o, bit [2:0] s, bit a, bit r);
      bit eh, eo, ea, cv, err, rej, bought, in_txn;
      bit [2:0] es, d;
      int coin, total, idx;
      d = 3'b000; cv = 1'b0; err = 1'b0; rej = 1'b0; bought = 1'b0;
      eh = h & ~mp_h; eo = o & ~mp_o; ea = a & ~mp_a; es = s & ~mp_s;
      mp_h = h; mp_o = o; mp_a = a; mp_s = s;
      if (r) begin
         m_credit = 0;
         m_amt    = 0;
         m_phase  = ST_IDLE;
         return pack(0, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0, ST_IDLE);
      end
      coin   = (eh ? 1 : 0) + (eo ? 2 : 0);
      in_txn = (m_phase == ST_DISPENSE) || (m_phase == ST_CHANGE);
      if (m_phase == ST_CREDIT && ea) begin
         total = m_credit;
         if (coin > 0) begin
            if (total + coin <= MAX_C) total += coin;
            else rej = 1'b1;
         end
         m_amt    = total;
         m_credit = 0;
         cv       = 1'b1;
         m_phase  = ST_CHANGE;
      end else begin
         if (!in_txn && es != 3'b000) begin
            idx = es[0] ? 0 : (es[1] ? 1 : 2);
            if (m_phase == ST_CREDIT && m_credit >= price[idx]) begin
               m_credit -= price[idx];
               d[idx]    = 1'b1;
               bought    = 1'b1;
            end else begin
               err = 1'b1;
            end
         end
         if (coin > 0) begin
            if (m_credit + coin <= MAX_C) m_credit += coin;
            else rej = 1'b1;
         end
         if (bought)            m_phase = ST_DISPENSE;
         else if (m_credit > 0) m_phase = ST_CREDIT;
         else                   m_phase = ST_IDLE;
      end
      return pack(m_credit, d, cv, m_amt, err, rej,
                  (m_phase == ST_DISPENSE) || (m_phase == ST_CHANGE), m_phase);
   endfunction

   // ---------------- driver ----------------
   task automatic cycle(input bit h, input bit o, input bit [2:0] s, input bit a, input bit r,
                        input bit use_tbl, input logic [OBS_W-1:0] tbl_exp,
                        input string name, input int idx);
      logic [OBS_W-1:0] m;
      @(negedge clk);
      coin_half = h;
      coin_one  = o;
      sel       = s;
      account   = a;
      rst       = r;
      m = model_step(h, o, s, a, r);
      exp_q.push_back(use_tbl ? tbl_exp : m);
      @(posedge clk);
      #1;
      check(name, idx);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit       h, o;
      bit [2:0] s;
      bit       a;
      int       cr;
      bit [2:0] d;
      bit       cv;
      int       amt;
      bit       err, rej, bsy;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit h, bit o, bit [2:0] s, bit a, int cr, bit [2:0] d,
                               bit cv, int amt, bit err, bit rej, bit bsy);
      vec_t v;
      v.h = h; v.o = o; v.s = s; v.a = a; v.cr = cr; v.d = d; v.cv = cv;
      v.amt = amt; v.err = err; v.rej = rej; v.bsy = bsy;
      vecs.push_back(v);
   endfunction

   function automatic state_t row_state(vec_t v);
      if (v.d != 3'b000) return ST_DISPENSE;
      if (v.cv)          return ST_CHANGE;
      if (v.cr != 0)     return ST_CREDIT;
      return ST_IDLE;
   endfunction

   function automatic void fill_table();
      // half then one, tea refused for low credit, refund
      add(1,0,3'b000,0, 1,3'b000,0,0, 0,0,0);
      add(0,1,3'b000,0, 3,3'b000,0,0, 0,0,0);
      add(0,0,3'b010,0, 3,3'b000,0,0, 1,0,0);
      add(0,0,3'b000,0, 3,3'b000,0,0, 0,0,0);
      add(0,0,3'b000,1, 0,3'b000,1,3, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,3, 0,0,0);
      // two one-yuan coins, buy cola, refund 1
      add(0,1,3'b000,0, 2,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,0, 2,3'b000,0,3, 0,0,0);
      add(0,1,3'b000,0, 4,3'b000,0,3, 0,0,0);
      add(0,0,3'b001,0, 1,3'b001,0,3, 0,0,1);
      add(0,0,3'b000,0, 1,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,1, 0,3'b000,1,1, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,1, 0,0,0);
      // held half coin counts once; milk bought together with a coin
      for (int i = 0; i < 10; i++) add(1,0,3'b000,0, 1,3'b000,0,1, 0,0,0);
      add(0,0,3'b000,0, 1,3'b000,0,1, 0,0,0);
      add(0,1,3'b000,0, 3,3'b000,0,1, 0,0,0);
      add(0,0,3'b000,0, 3,3'b000,0,1, 0,0,0);
      add(0,1,3'b000,0, 5,3'b000,0,1, 0,0,0);
      add(0,0,3'b000,0, 5,3'b000,0,1, 0,0,0);
      add(1,0,3'b000,0, 6,3'b000,0,1, 0,0,0);
      add(0,0,3'b000,0, 6,3'b000,0,1, 0,0,0);
      add(0,1,3'b100,0, 2,3'b100,0,1, 0,0,1);
      add(0,0,3'b000,0, 2,3'b000,0,1, 0,0,0);
      add(0,0,3'b000,1, 0,3'b000,1,2, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,2, 0,0,0);
      // fill to 39, then the credit ceiling
      for (int k = 1; k <= 19; k++) begin
         add(0,1,3'b000,0, 2*k,3'b000,0,2, 0,0,0);
         add(0,0,3'b000,0, 2*k,3'b000,0,2, 0,0,0);
      end
      add(1,0,3'b000,0, 39,3'b000,0,2, 0,0,0);
      add(0,0,3'b000,0, 39,3'b000,0,2, 0,0,0);
      add(1,1,3'b000,0, 39,3'b000,0,2, 0,1,0);
      add(0,0,3'b000,0, 39,3'b000,0,2, 0,0,0);
      add(1,0,3'b000,0, 40,3'b000,0,2, 0,0,0);
      add(0,0,3'b000,0, 40,3'b000,0,2, 0,0,0);
      add(1,0,3'b000,0, 40,3'b000,0,2, 0,1,0);
      add(0,0,3'b000,0, 40,3'b000,0,2, 0,0,0);
      add(0,0,3'b000,1, 0,3'b000,1,40, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,40, 0,0,0);
      // multi-select picks cola; account wins over sel
      add(0,1,3'b000,0, 2,3'b000,0,40, 0,0,0);
      add(0,0,3'b000,0, 2,3'b000,0,40, 0,0,0);
      add(0,1,3'b000,0, 4,3'b000,0,40, 0,0,0);
      add(0,0,3'b000,0, 4,3'b000,0,40, 0,0,0);
      add(0,1,3'b000,0, 6,3'b000,0,40, 0,0,0);
      add(0,0,3'b000,0, 6,3'b000,0,40, 0,0,0);
      add(0,0,3'b111,0, 3,3'b001,0,40, 0,0,1);
      add(0,0,3'b000,0, 3,3'b000,0,40, 0,0,0);
      add(0,0,3'b010,1, 0,3'b000,1,3, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,3, 0,0,0);
      // IDLE: account ignored, sel refused
      add(0,0,3'b000,1, 0,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,0, 0,3'b000,0,3, 0,0,0);
      add(0,0,3'b001,0, 0,3'b000,0,3, 1,0,0);
      add(0,0,3'b000,0, 0,3'b000,0,3, 0,0,0);
      // DISPENSE: sel discarded, coin credited
      add(0,1,3'b000,0, 2,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,0, 2,3'b000,0,3, 0,0,0);
      add(0,1,3'b000,0, 4,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,0, 4,3'b000,0,3, 0,0,0);
      add(0,0,3'b001,0, 1,3'b001,0,3, 0,0,1);
      add(1,0,3'b011,0, 2,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,0, 2,3'b000,0,3, 0,0,0);
      add(0,0,3'b000,1, 0,3'b000,1,2, 0,0,1);
      add(0,0,3'b000,0, 0,3'b000,0,2, 0,0,0);
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [OBS_W-1:0] zero_idle;
      bit h, o, a, r;
      bit [2:0] s;
      zero_idle = pack(0, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0, ST_IDLE);
      fill_table();

      // reset state
      cycle(0,0,3'b000,0,1, 1, zero_idle, "reset", 0);
      cycle(0,0,3'b000,0,1, 1, zero_idle, "reset", 1);

      // directed table
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].h, vecs[i].o, vecs[i].s, vecs[i].a, 1'b0, 1'b1,
               pack(vecs[i].cr, vecs[i].d, vecs[i].cv, vecs[i].amt, vecs[i].err,
                    vecs[i].rej, vecs[i].bsy, row_state(vecs[i])),
               "vec", i);
      end

      // reset during DISPENSE aborts and loses credit; held sel stays quiet
      cycle(0,0,3'b000,0,1, 1, zero_idle, "abort", 0);
      cycle(0,1,3'b000,0,0, 1, pack(2,3'b000,0,0,0,0,0,ST_CREDIT), "abort", 1);
      cycle(0,0,3'b000,0,0, 1, pack(2,3'b000,0,0,0,0,0,ST_CREDIT), "abort", 2);
      cycle(0,1,3'b000,0,0, 1, pack(4,3'b000,0,0,0,0,0,ST_CREDIT), "abort", 3);
      cycle(0,0,3'b000,0,0, 1, pack(4,3'b000,0,0,0,0,0,ST_CREDIT), "abort", 4);
      cycle(0,0,3'b001,0,0, 1, pack(1,3'b001,0,0,0,0,1,ST_DISPENSE), "abort", 5);
      cycle(0,0,3'b001,0,1, 1, zero_idle, "abort", 6);
      cycle(0,0,3'b001,0,0, 1, zero_idle, "abort", 7);
      cycle(0,0,3'b000,0,0, 1, zero_idle, "abort", 8);

      // random stimulus against the model
      cycle(0,0,3'b000,0,1, 0, '0, "rand_reset", 0);
      h = 1'b0; o = 1'b0; a = 1'b0; s = 3'b000;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 30) h = ~h;
         if ($urandom_range(0, 99) < 30) o = ~o;
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 99) < 10) s[b] = ~s[b];
         if ($urandom_range(0, 99) < 8) a = ~a;
         r = ($urandom_range(0, 199) == 0);
         cycle(h, o, s, a, r, 1'b0, '0, "rand", n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
